ex_stage: RTL and testbench

Execute stage of the five-stage pipelined processor, between `ID_STAGE` (ID/EX register) and the memory stage. Each cycle it takes the ID/EX bundle and computes the ALU result, store data, destination register and branch decision. It registers these into the EX/MEM pipeline register and returns the branch redirect to `IF_STAGE`. Multiply is executed by an iterative 32-cycle unit that stalls the front of the pipe.

---
 rtl/proc_pkg.sv | 37 +++
 rtl/ex_multiplier.sv | 69 ++++++
 rtl/ex_stage.sv | 201 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared definitions for the five-stage pipeline. This file
//                holds the datapath widths, the ALUOp and R-type funct
//                encodings, and the multiply sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 8;

    // ALUOp encodings produced by the decoder. The reserved code behaves as add.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // R-type funct field values, taken from SignExtImm[5:0].
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    // States of the multiply sequencer in the execute stage.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ex_multiplier
//  Description : Iterative shift-add multiplier. It performs one step per
//                clock over MUL_CYCLES steps and produces the low DATA_W bits
//                of the product.
//                Ports: clk, rst (async, active-low), start (loads operands),
//                multiplicand, multiplier, product (accumulator),
//                done (high during the final step; product valid next cycle).
//  Revision    : 1.0  initial release
// ============================================================================
module ex_multiplier #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic [DATA_W-1:0] product,
    output logic              done
);

    localparam int c_cnt_w = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MUL_CYCLES - 1);

    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [c_cnt_w-1:0] r_count;
    logic               r_busy;

    // The low DATA_W bits of a two's-complement product equal those of the
    // unsigned product. Plain modulo shift-add therefore gives the signed
    // result without any sign correction, as long as MUL_CYCLES covers
    // DATA_W bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + c_cnt_w'(1);
            if (r_count == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign product = r_acc;
    assign done    = r_busy && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage. It takes the ID/EX bundle, computes the ALU
//                result, destination and beq decision, and registers them
//                into EX/MEM. Multiply runs on an iterative unit and stalls
//                the front of the pipe while it works.
//                Inputs : ID/EX operands, immediate, Rb/Rd, PC, control.
//                Outputs: EX/MEM result/store data/dest/control (registered),
//                         BranchTaken/BranchTarget (registered redirect),
//                         Stall (combinational freeze of PC, IF/ID, ID/EX).
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage #(
    parameter int DATA_W     = proc_pkg::DATA_W,
    parameter int PC_W       = proc_pkg::PC_W,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ID_EX_ReadData1,
    input  logic [DATA_W-1:0] ID_EX_ReadData2,
    input  logic [DATA_W-1:0] ID_EX_SignExtImm,
    input  logic [4:0]        ID_EX_Rb,
    input  logic [4:0]        ID_EX_Rd,
    input  logic [PC_W-1:0]   ID_EX_PC,
    input  logic              ID_EX_RegDst,
    input  logic              ID_EX_ALUSrc,
    input  logic              ID_EX_MemToReg,
    input  logic              ID_EX_RegWrite,
    input  logic              ID_EX_MemRead,
    input  logic              ID_EX_MemWrite,
    input  logic              ID_EX_Branch,
    input  logic [1:0]        ID_EX_ALUOp,
    output logic [DATA_W-1:0] EX_MEM_ALUResult,
    output logic [DATA_W-1:0] EX_MEM_WriteData,
    output logic [4:0]        EX_MEM_WriteReg,
    output logic              EX_MEM_MemToReg,
    output logic              EX_MEM_RegWrite,
    output logic              EX_MEM_MemRead,
    output logic              EX_MEM_MemWrite,
    output logic              BranchTaken,
    output logic [PC_W-1:0]   BranchTarget,
    output logic              Stall
);

    import proc_pkg::*;

    // ------------------------------------------------------------------
    // Operand selection and decode
    // ------------------------------------------------------------------
    logic [5:0]        w_funct;
    logic              w_is_mult;
    logic [DATA_W-1:0] w_op_b;
    logic [4:0]        w_dest;

    assign w_funct   = ID_EX_SignExtImm[5:0];
    assign w_is_mult = (ID_EX_ALUOp == ALUOP_RTYPE) && (w_funct == FUNCT_MULT);
    assign w_op_b    = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2;
    assign w_dest    = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rb;

    // ------------------------------------------------------------------
    // ALU. An unsupported funct still yields the add result, but its
    // register write is suppressed so the instruction has no effect.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_alu_result;
    logic              w_funct_ok;
    logic              w_slt;

    assign w_slt = $signed(ID_EX_ReadData1) < $signed(w_op_b);

    always_comb begin
        w_alu_result = ID_EX_ReadData1 + w_op_b;
        w_funct_ok   = 1'b1;
        case (ID_EX_ALUOp)
            ALUOP_SUB: w_alu_result = ID_EX_ReadData1 - w_op_b;
            ALUOP_RTYPE: begin
                case (w_funct)
                    FUNCT_ADD:  w_alu_result = ID_EX_ReadData1 + w_op_b;
                    FUNCT_SUB:  w_alu_result = ID_EX_ReadData1 - w_op_b;
                    FUNCT_AND:  w_alu_result = ID_EX_ReadData1 & w_op_b;
                    FUNCT_OR:   w_alu_result = ID_EX_ReadData1 | w_op_b;
                    FUNCT_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, w_slt};
                    FUNCT_MULT: w_alu_result = ID_EX_ReadData1 + w_op_b;
                    default:    w_funct_ok   = 1'b0;
                endcase
            end
            default: w_alu_result = ID_EX_ReadData1 + w_op_b;
        endcase
    end

    // ------------------------------------------------------------------
    // beq: compare the register operands directly, independent of ALUSrc.
    // The word offset is taken from the low six immediate bits, and the
    // sum wraps within the PC width.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_br_diff;
    logic              w_branch_taken;
    logic [7:0]        w_br_offset;
    logic [PC_W-1:0]   w_br_target;

    assign w_br_diff      = ID_EX_ReadData1 - ID_EX_ReadData2;
    assign w_branch_taken = ID_EX_Branch && (w_br_diff == '0);
    assign w_br_offset    = {ID_EX_SignExtImm[5:0], 2'b00};
    assign w_br_target    = ID_EX_PC + PC_W'(w_br_offset);

    // ------------------------------------------------------------------
    // Multiply sequencer
    // ------------------------------------------------------------------
    mul_state_e        r_state;
    logic              w_mul_start;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_product;

    assign w_mul_start = (r_state == ST_IDLE) && w_is_mult;
    // Low in DONE so that ID/EX advances on the same edge that writes the product.
    assign Stall       = w_mul_start || (r_state == ST_MUL);

    ex_multiplier #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk          (clk),
        .rst          (rst),
        .start        (w_mul_start),
        .multiplicand (ID_EX_ReadData1),
        .multiplier   (w_op_b),
        .product      (w_product),
        .done         (w_mul_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_is_mult)  r_state <= ST_MUL;
                ST_MUL:  if (w_mul_done) r_state <= ST_DONE;
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM pipeline register. While stalled, a bubble is inserted with
    // all control cleared. The data fields keep their old contents.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_write_data;
    logic [4:0]        r_write_reg;
    logic              r_mem_to_reg;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_branch_taken;
    logic [PC_W-1:0]   r_branch_target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_result    <= '0;
            r_write_data    <= '0;
            r_write_reg     <= '0;
            r_mem_to_reg    <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
        end else if (Stall) begin
            r_mem_to_reg   <= 1'b0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_branch_taken <= 1'b0;
        end else begin
            r_alu_result    <= (r_state == ST_DONE) ? w_product : w_alu_result;
            r_write_data    <= ID_EX_ReadData2;
            r_write_reg     <= w_dest;
            r_mem_to_reg    <= ID_EX_MemToReg;
            r_reg_write     <= ID_EX_RegWrite && w_funct_ok;
            r_mem_read      <= ID_EX_MemRead;
            r_mem_write     <= ID_EX_MemWrite;
            r_branch_taken  <= w_branch_taken;
            r_branch_target <= w_br_target;
        end
    end

    assign EX_MEM_ALUResult = r_alu_result;
    assign EX_MEM_WriteData = r_write_data;
    assign EX_MEM_WriteReg  = r_write_reg;
    assign EX_MEM_MemToReg  = r_mem_to_reg;
    assign EX_MEM_RegWrite  = r_reg_write;
    assign EX_MEM_MemRead   = r_mem_read;
    assign EX_MEM_MemWrite  = r_mem_write;
    assign BranchTaken      = r_branch_taken;
    assign BranchTarget     = r_branch_target;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Scoreboard testbench for ex_stage. The stimulus process
//                queues hand-computed expectations tagged with a cycle number.
//                A monitor on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rb, rd;
    logic [7:0]  pc;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op;
    logic [31:0] alu_result, write_data;
    logic [4:0]  write_reg;
    logic        o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        stall;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ID_EX_ReadData1  (rd1),
        .ID_EX_ReadData2  (rd2),
        .ID_EX_SignExtImm (imm),
        .ID_EX_Rb         (rb),
        .ID_EX_Rd         (rd),
        .ID_EX_PC         (pc),
        .ID_EX_RegDst     (reg_dst),
        .ID_EX_ALUSrc     (alu_src),
        .ID_EX_MemToReg   (mem_to_reg),
        .ID_EX_RegWrite   (reg_write),
        .ID_EX_MemRead    (mem_read),
        .ID_EX_MemWrite   (mem_write),
        .ID_EX_Branch     (branch),
        .ID_EX_ALUOp      (alu_op),
        .EX_MEM_ALUResult (alu_result),
        .EX_MEM_WriteData (write_data),
        .EX_MEM_WriteReg  (write_reg),
        .EX_MEM_MemToReg  (o_mem_to_reg),
        .EX_MEM_RegWrite  (o_reg_write),
        .EX_MEM_MemRead   (o_mem_read),
        .EX_MEM_MemWrite  (o_mem_write),
        .BranchTaken      (branch_taken),
        .BranchTarget     (branch_target),
        .Stall            (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // control vector order: {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch}
    localparam logic [6:0] CTL_LW  = 7'b0111100;
    localparam logic [6:0] CTL_SW  = 7'b0100010;
    localparam logic [6:0] CTL_R   = 7'b1001000;
    localparam logic [6:0] CTL_BEQ = 7'b0000001;
    localparam logic [6:0] CTL_NOP = 7'b0000000;

    typedef struct {
        int          cyc;
        bit          chk_out;
        bit          chk_stall;
        logic        stall;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [3:0]  ctl;   // {MemToReg, RegWrite, MemRead, MemWrite}
        logic        bt;
        logic [7:0]  btgt;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [3:0]  got_ctl;
        logic        bad;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_checks++;
            got_ctl = {o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write};
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d", e.name, e.cyc, cyc);
            end else begin
                bad = 1'b0;
                if (e.chk_out && ({alu_result, write_data, write_reg, got_ctl, branch_taken, branch_target}
                                  !== {e.alu, e.wd, e.wr, e.ctl, e.bt, e.btgt}))
                    bad = 1'b1;
                if (e.chk_stall && (stall !== e.stall))
                    bad = 1'b1;
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got alu=%h wd=%h wr=%0d ctl=%b bt=%b tgt=%h stall=%b, expected alu=%h wd=%h wr=%0d ctl=%b bt=%b tgt=%h stall=%b (chk_out=%0d chk_stall=%0d)",
                             e.name, cyc, alu_result, write_data, write_reg, got_ctl, branch_taken,
                             branch_target, stall, e.alu, e.wd, e.wr, e.ctl, e.bt, e.btgt, e.stall,
                             e.chk_out, e.chk_stall);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input string name, input int c, input bit chk_out, input bit chk_stall,
                        input logic st, input logic [31:0] a, input logic [31:0] w,
                        input logic [4:0] r, input logic [3:0] ct, input logic b,
                        input logic [7:0] t);
        exp_t e;
        e.cyc = c; e.chk_out = chk_out; e.chk_stall = chk_stall; e.stall = st;
        e.alu = a; e.wd = w; e.wr = r; e.ctl = ct; e.bt = b; e.btgt = t; e.name = name;
        q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] r_b, input logic [4:0] r_d, input logic [7:0] p,
                         input logic [6:0] ctl, input logic [1:0] op);
        rd1 = a; rd2 = b; imm = im; rb = r_b; rd = r_d; pc = p; alu_op = op;
        {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = ctl;
    endtask

    // Expect Stall for the current cycle and (optionally) the EX/MEM contents
    // visible during the next cycle, then advance one clock.
    task automatic expect_cycle(input string name, input logic st, input bit chk_next,
                                input logic [31:0] a, input logic [31:0] w, input logic [4:0] r,
                                input logic [3:0] ct, input logic b, input logic [7:0] t);
        push({name, "_stall"}, cyc, 1'b0, 1'b1, st, '0, '0, '0, '0, 1'b0, '0);
        if (chk_next)
            push(name, cyc + 1, 1'b1, 1'b0, 1'b0, a, w, r, ct, b, t);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 8'h00, CTL_NOP, 2'b00);
        @(posedge clk); #1;
        push("reset", cyc, 1'b1, 1'b1, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1;

        drive(32'h100, 32'h55, 32'd8, 5'd5, 5'd0, 8'h10, CTL_LW, 2'b00);
        expect_cycle("lw", 0, 1, 32'h108, 32'h55, 5'd5, 4'b1110, 0, 8'h30);
        drive(32'h200, 32'hDEADBEEF, 32'hFFFFFFFC, 5'd7, 5'd0, 8'h14, CTL_SW, 2'b00);
        expect_cycle("sw", 0, 1, 32'h1FC, 32'hDEADBEEF, 5'd7, 4'b0001, 0, 8'h04);
        drive(32'd5, 32'd7, 32'h22, 5'd9, 5'd3, 8'h18, CTL_R, 2'b10);
        expect_cycle("sub", 0, 1, 32'hFFFFFFFE, 32'd7, 5'd3, 4'b0100, 0, 8'hA0);
        drive(32'hFFFFFFFF, 32'd2, 32'h2A, 5'd9, 5'd4, 8'h1C, CTL_R, 2'b10);
        expect_cycle("slt", 0, 1, 32'd1, 32'd2, 5'd4, 4'b0100, 0, 8'hC4);
        drive(32'hF0F0F0F0, 32'hFF00FF00, 32'h24, 5'd9, 5'd6, 8'h20, CTL_R, 2'b10);
        expect_cycle("and", 0, 1, 32'hF000F000, 32'hFF00FF00, 5'd6, 4'b0100, 0, 8'hB0);
        drive(32'hF0F0F0F0, 32'hFF00FF00, 32'h25, 5'd9, 5'd8, 8'h24, CTL_R, 2'b10);
        expect_cycle("or", 0, 1, 32'hFFF0FFF0, 32'hFF00FF00, 5'd8, 4'b0100, 0, 8'hB8);
        drive(32'd3, 32'd4, 32'h27, 5'd9, 5'd10, 8'h28, CTL_R, 2'b10);
        expect_cycle("bad_funct", 0, 1, 32'd7, 32'd4, 5'd10, 4'b0000, 0, 8'hC4);
        drive(32'hFFFFFFFF, 32'd2, 32'h20, 5'd9, 5'd11, 8'h2C, CTL_R, 2'b10);
        expect_cycle("add_wrap", 0, 1, 32'd1, 32'd2, 5'd11, 4'b0100, 0, 8'hAC);
        drive(32'h1234, 32'h1234, 32'd2, 5'd1, 5'd0, 8'hFC, CTL_BEQ, 2'b01);
        expect_cycle("beq_taken", 0, 1, 32'd0, 32'h1234, 5'd1, 4'b0000, 1, 8'h04);
        drive(0, 0, 0, 0, 0, 8'h00, CTL_NOP, 2'b00);
        expect_cycle("beq_one_cycle", 0, 1, 32'd0, 32'd0, 5'd0, 4'b0000, 0, 8'h00);
        drive(32'd1, 32'd2, 32'd3, 5'd2, 5'd0, 8'h40, CTL_BEQ, 2'b01);
        expect_cycle("beq_not_taken", 0, 1, 32'hFFFFFFFF, 32'd2, 5'd2, 4'b0000, 0, 8'h4C);

        // mult -3 * 6: 33 stall cycles with bubbles, then the product
        drive(32'hFFFFFFFD, 32'd6, 32'h18, 5'd0, 5'd12, 8'h50, CTL_R, 2'b10);
        for (int i = 0; i < 33; i++)
            expect_cycle("mult_bubble", 1, 1, 32'hFFFFFFFF, 32'd2, 5'd2, 4'b0000, 0, 8'h4C);
        expect_cycle("mult_done", 0, 1, 32'hFFFFFFEE, 32'd6, 5'd12, 4'b0100, 0, 8'hB0);
        drive(32'd10, 32'd20, 32'h20, 5'd0, 5'd13, 8'h54, CTL_R, 2'b10);
        expect_cycle("add_after_mult", 0, 1, 32'd30, 32'd20, 5'd13, 4'b0100, 0, 8'hD4);

        // mult aborted by reset at its 10th cycle, then rerun from scratch
        drive(32'h12345678, 32'h10, 32'h18, 5'd0, 5'd12, 8'h50, CTL_R, 2'b10);
        for (int i = 0; i < 10; i++)
            expect_cycle("mult2_bubble", 1, (i < 9), 32'd30, 32'd20, 5'd13, 4'b0000, 0, 8'hD4);
        rst = 1'b0;
        push("reset_mid_mult", cyc, 1'b1, 1'b1, 1'b1, '0, '0, '0, '0, 1'b0, '0);
        @(posedge clk); #1;
        rst = 1'b1;
        push("reset_release", cyc, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 33; i++)
            expect_cycle("mult2_rerun_bubble", 1, 1, 32'd0, 32'd0, 5'd0, 4'b0000, 0, 8'h00);
        expect_cycle("mult2_done", 0, 1, 32'h23456780, 32'h10, 5'd12, 4'b0100, 0, 8'hB0);
        drive(0, 0, 0, 0, 0, 8'h00, CTL_NOP, 2'b00);
        expect_cycle("nop_end", 0, 1, 32'd0, 32'd0, 5'd0, 4'b0000, 0, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
